// File: rtl/bdsr_nibble_feeder_if.sv
`default_nettype none
// =====================================================================
// Module   : bdsr_nibble_feeder_if
// Summary  : Word handshake plus serial outputs of the nibble feeder.
// Revision : 1.0
// =====================================================================
interface bdsr_nibble_feeder_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_word;
    logic             in_dir;
    logic             X;
    logic             Data;
    logic             shift_en;
    logic             word_done;
    logic             busy;

    modport master (
        output in_valid, in_word, in_dir,
        input  in_ready, X, Data, shift_en, word_done, busy
    );

    modport slave (
        input  in_valid, in_word, in_dir,
        output in_ready, X, Data, shift_en, word_done, busy
    );
endinterface
`default_nettype wire

// File: rtl/bdsr_nibble_feeder.sv
`default_nettype none
// =====================================================================
// Module   : bdsr_nibble_feeder
// Summary  : FIFO-buffered serialiser feeding a bidirectional shift register.
// Revision : 1.0
// =====================================================================
module bdsr_nibble_feeder #(
    parameter int   WIDTH = 4,
    parameter int   DEPTH = 2,
    parameter int   GAP   = 0,
    parameter logic FILL  = 1'b0
) (
    input wire                  clock,
    input wire                  reset,
    bdsr_nibble_feeder_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    // FIFO storage and bookkeeping
    logic [WIDTH:0]   mem_q [DEPTH];
    logic [WIDTH:0]   mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [WIDTH:0]   head;

    // Serialiser state
    logic [1:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             dir_q, dir_d;
    logic [3:0]       gap_q, gap_d;
    logic             load;

    // Registered outputs
    logic             in_ready_q, in_ready_d;
    logic             x_q, x_d;
    logic             data_q, data_d;
    logic             shift_en_q, shift_en_d;
    logic             word_done_q, word_done_d;
    logic             busy_q, busy_d;
    logic [KW-1:0]    bit_idx;

    assign push       = bus.in_valid && in_ready_q;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = {bus.in_dir, bus.in_word};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Next-state logic: a load pops the FIFO head straight into bit 0
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        word_d  = word_q;
        dir_d   = dir_q;
        gap_d   = gap_q;
        load    = 1'b0;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                load = !fifo_empty;
            end
            S_SHIFT: begin
                if (k_q == K_LAST) begin
                    if (GAP > 0) begin
                        state_d = S_WAIT;
                        gap_d   = 4'd0;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (gap_q == GAP_LAST) begin
                    if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (load) begin
            pop             = 1'b1;
            state_d         = S_SHIFT;
            k_d             = '0;
            {dir_d, word_d} = head;
        end
    end

    // Outputs are computed from the next state so they register alongside it
    always_comb begin
        shift_en_d  = (state_d == S_SHIFT);
        bit_idx     = dir_d ? k_d : (K_LAST - k_d);
        data_d      = shift_en_d ? word_d[bit_idx] : FILL;
        x_d         = shift_en_d ? dir_d : x_q;
        word_done_d = shift_en_d && (k_d == K_LAST);
        busy_d      = (count_d != '0) || (state_d != S_IDLE);
        in_ready_d  = (count_d < CW'(DEPTH));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            k_q         <= '0;
            word_q      <= '0;
            dir_q       <= 1'b0;
            gap_q       <= 4'd0;
            in_ready_q  <= 1'b0;
            x_q         <= 1'b0;
            data_q      <= FILL;
            shift_en_q  <= 1'b0;
            word_done_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            k_q         <= k_d;
            word_q      <= word_d;
            dir_q       <= dir_d;
            gap_q       <= gap_d;
            in_ready_q  <= in_ready_d;
            x_q         <= x_d;
            data_q      <= data_d;
            shift_en_q  <= shift_en_d;
            word_done_q <= word_done_d;
            busy_q      <= busy_d;
        end
    end

    // Entries are only read after a counted write, so storage needs no reset
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.X         = x_q;
    assign bus.Data      = data_q;
    assign bus.shift_en  = shift_en_q;
    assign bus.word_done = word_done_q;
    assign bus.busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_bdsr_nibble_feeder.sv
`default_nettype none
// =====================================================================
// Module   : tb_bdsr_nibble_feeder
// Summary  : Directed checks of the nibble feeder (GAP=0 and GAP=3 copies).
// Revision : 1.0
// =====================================================================
module tb_bdsr_nibble_feeder;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tb_valid = 1'b0;
    logic [3:0] tb_word  = 4'h0;
    logic       tb_dir   = 1'b0;

    int total = 0;
    int bad   = 0;

    // Downstream 4-bit register {A,B,C,D} fed by copy A
    logic [3:0] ds_q;

    // Burst-test bookkeeping
    logic [3:0] words [4] = '{4'h9, 4'h6, 4'hC, 4'h5};
    logic       dirs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int         accepted;
    int         low_at;
    int         nb;
    int         nw;
    int         en_cnt;
    int         busy_cnt;
    logic [3:0] acc_w;

    always #5 clock = ~clock;

    bdsr_nibble_feeder_if #(.WIDTH(4)) ifa ();
    bdsr_nibble_feeder_if #(.WIDTH(4)) ifb ();

    assign ifa.in_valid = tb_valid;
    assign ifa.in_word  = tb_word;
    assign ifa.in_dir   = tb_dir;
    assign ifb.in_valid = tb_valid;
    assign ifb.in_word  = tb_word;
    assign ifb.in_dir   = tb_dir;

    bdsr_nibble_feeder #(.WIDTH(4), .DEPTH(2), .GAP(0), .FILL(1'b0)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa.slave)
    );

    bdsr_nibble_feeder #(.WIDTH(4), .DEPTH(2), .GAP(3), .FILL(1'b1)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb.slave)
    );

    always @(negedge clock) begin
        if (reset) begin
            ds_q <= 4'h0;
        end else if (ifa.shift_en) begin
            ds_q <= ifa.X ? {ifa.Data, ds_q[3:1]} : {ds_q[2:0], ifa.Data};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        tb_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Offer a word at this falling edge; returns at the falling edge after it was taken
    task automatic push_word(input logic [3:0] w, input logic d);
        int n;
        tb_valid = 1'b1;
        tb_word  = w;
        tb_dir   = d;
        n = 0;
        while (!ifa.in_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) check("push_timeout", 32'd0, 32'd1);
        @(negedge clock);
    endtask

    // seq holds the expected Data bits, first bit in seq[3]
    task automatic expect_seq(input string tag, input bit sel, input logic [3:0] seq, input logic x);
        for (int i = 0; i < 4; i++) begin
            check({tag, "_en"},   sel ? ifb.shift_en  : ifa.shift_en,  1'b1);
            check({tag, "_data"}, sel ? ifb.Data      : ifa.Data,      seq[3-i]);
            check({tag, "_x"},    sel ? ifb.X         : ifa.X,         x);
            check({tag, "_done"}, sel ? ifb.word_done : ifa.word_done, (i == 3) ? 1'b1 : 1'b0);
            @(negedge clock);
        end
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clock);
        check("rst_ready", ifa.in_ready,  1'b0);
        check("rst_x",     ifa.X,         1'b0);
        check("rst_data",  ifa.Data,      1'b0);
        check("rst_en",    ifa.shift_en,  1'b0);
        check("rst_done",  ifa.word_done, 1'b0);
        check("rst_busy",  ifa.busy,      1'b0);
        check("rst_fillb", ifb.Data,      1'b1);
        reset = 1'b0;
        @(negedge clock);
        check("ready_after_rst", ifa.in_ready, 1'b1);

        // 1011, shift right
        push_word(4'b1011, 1'b1);
        tb_valid = 1'b0;
        check("t1_latency_en", ifa.shift_en, 1'b0);
        check("t1_busy_early", ifa.busy,     1'b1);
        @(negedge clock);
        expect_seq("t1", 1'b0, 4'b1101, 1'b1);
        check("t1_busy_after", ifa.busy,     1'b0);
        check("t1_en_after",   ifa.shift_en, 1'b0);
        check("t1_fill_after", ifa.Data,     1'b0);
        check("t1_x_hold",     ifa.X,        1'b1);
        check("t1_ds",         ds_q,         4'b1011);

        // 1011, shift left
        do_reset();
        push_word(4'b1011, 1'b0);
        tb_valid = 1'b0;
        @(negedge clock);
        expect_seq("t2", 1'b0, 4'b1011, 1'b0);
        check("t2_ds", ds_q, 4'b1011);

        // A (right) then 3 (left) back to back
        do_reset();
        push_word(4'hA, 1'b1);
        push_word(4'h3, 1'b0);
        tb_valid = 1'b0;
        expect_seq("t3a", 1'b0, 4'b0101, 1'b1);
        expect_seq("t3b", 1'b0, 4'b0011, 1'b0);
        check("t3_en_end", ifa.shift_en, 1'b0);
        check("t3_ds",     ds_q,         4'h3);

        // Four words offered with in_valid held high
        do_reset();
        accepted = 0;
        low_at   = -1;
        nb       = 0;
        nw       = 0;
        en_cnt   = 0;
        acc_w    = 4'h0;
        fork
            begin
                for (int j = 0; j < 4; j++) begin
                    int n;
                    tb_valid = 1'b1;
                    tb_word  = words[j];
                    tb_dir   = dirs[j];
                    n = 0;
                    while (!ifa.in_ready && n < 20) begin
                        if (low_at < 0) low_at = accepted;
                        @(negedge clock);
                        n++;
                    end
                    @(negedge clock);
                    accepted++;
                end
                tb_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    if (ifa.shift_en) begin
                        en_cnt++;
                        if (ifa.X) acc_w[nb] = ifa.Data;
                        else       acc_w[3-nb] = ifa.Data;
                        nb++;
                        if (nb == 4) begin
                            check("t4_done", ifa.word_done, 1'b1);
                            if (nw < 4) begin
                                check("t4_word", acc_w,  words[nw]);
                                check("t4_dir",  ifa.X,  dirs[nw]);
                            end else begin
                                check("t4_extra_word", 32'(nw), 32'd3);
                            end
                            nw++;
                            nb = 0;
                        end
                    end
                    @(negedge clock);
                end
            end
        join
        // The first word leaves the FIFO one cycle after landing, so it fills on the third accept
        check("t4_ready_low_at", low_at, 3);
        check("t4_nwords",       nw,     4);
        check("t4_en_cycles",    en_cnt, 16);

        // GAP=3 copy: two words separated by three fill cycles
        do_reset();
        push_word(4'b0110, 1'b1);
        push_word(4'b1001, 1'b0);
        tb_valid = 1'b0;
        expect_seq("t5a", 1'b1, 4'b0110, 1'b1);
        for (int g = 0; g < 3; g++) begin
            check("t5_gap_en",   ifb.shift_en, 1'b0);
            check("t5_gap_fill", ifb.Data,     1'b1);
            @(negedge clock);
        end
        expect_seq("t5b", 1'b1, 4'b1001, 1'b0);
        check("t5_en_end", ifb.shift_en, 1'b0);

        // Reset in the middle of a word with one more queued
        do_reset();
        push_word(4'hF, 1'b1);
        push_word(4'hF, 1'b0);
        tb_valid = 1'b0;
        check("t6_bit0", ifa.shift_en, 1'b1);
        repeat (2) @(negedge clock);
        check("t6_bit2", ifa.shift_en, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        check("t6_rst_ready", ifa.in_ready,  1'b0);
        check("t6_rst_x",     ifa.X,         1'b0);
        check("t6_rst_data",  ifa.Data,      1'b0);
        check("t6_rst_en",    ifa.shift_en,  1'b0);
        check("t6_rst_done",  ifa.word_done, 1'b0);
        check("t6_rst_busy",  ifa.busy,      1'b0);
        check("t6_rst_fillb", ifb.Data,      1'b1);
        reset    = 1'b0;
        en_cnt   = 0;
        busy_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            if (ifa.shift_en) en_cnt++;
            if (ifa.busy)     busy_cnt++;
        end
        check("t6_no_bits",  en_cnt,       0);
        check("t6_no_busy",  busy_cnt,     0);
        check("t6_ready",    ifa.in_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
